// File: rtl/stopwatch_display_scan.sv
// ============================================================================
// Module  : stopwatch_display_scan
// Purpose : Scans four BCD digits (MM:SS) onto an active-low 4-digit 7-segment
//           display, with frame-synchronous shadowing and adjust-mode blinking.
// Revision: 1.0
// ============================================================================
`default_nettype none

module stopwatch_display_scan #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 25000000
) (
  input  logic       master_clk,
  input  logic       rst,
  input  logic [3:0] min_tens,
  input  logic [3:0] min_ones,
  input  logic [3:0] sec_tens,
  input  logic [3:0] sec_ones,
  input  logic       adj,
  input  logic       sel,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an
);

  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [RW-1:0] c_REFRESH_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] c_BLINK_LAST   = BW'(BLINK_DIV - 1);
  localparam logic [6:0]    c_SEG_OFF      = 7'b1111111;
  localparam logic [3:0]    c_AN_OFF       = 4'b1111;

  logic [RW-1:0] refresh_cnt_q, refresh_cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_ph_q, blink_ph_d;
  logic [3:0]    sh_min_tens_q, sh_min_ones_q, sh_sec_tens_q, sh_sec_ones_q;
  logic [3:0]    sh_min_tens_d, sh_min_ones_d, sh_sec_tens_d, sh_sec_ones_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic [3:0]    an_q, an_d;

  logic          w_refresh_wrap;
  logic          w_blink_wrap;
  logic          w_blank;
  logic [3:0]    w_digit;
  logic [6:0]    w_seg_dec;

  assign w_refresh_wrap = (refresh_cnt_q == c_REFRESH_LAST);
  assign w_blink_wrap   = (blink_cnt_q == c_BLINK_LAST);

  always_comb begin
    refresh_cnt_d = w_refresh_wrap ? '0 : refresh_cnt_q + RW'(1);
    idx_d         = w_refresh_wrap ? idx_q + 2'd1 : idx_q;
  end

  // Inputs are only sampled at the frame boundary so a frame never mixes old/new time.
  always_comb begin
    sh_min_tens_d = sh_min_tens_q;
    sh_min_ones_d = sh_min_ones_q;
    sh_sec_tens_d = sh_sec_tens_q;
    sh_sec_ones_d = sh_sec_ones_q;
    if (w_refresh_wrap && (idx_q == 2'd3)) begin
      sh_min_tens_d = min_tens;
      sh_min_ones_d = min_ones;
      sh_sec_tens_d = sec_tens;
      sh_sec_ones_d = sec_ones;
    end
  end

  always_comb begin
    blink_cnt_d = '0;
    blink_ph_d  = 1'b0;
    if (adj) begin
      blink_cnt_d = w_blink_wrap ? '0 : blink_cnt_q + BW'(1);
      blink_ph_d  = w_blink_wrap ? ~blink_ph_q : blink_ph_q;
    end
  end

  always_comb begin
    case (idx_q)
      2'd0:    w_digit = sh_sec_ones_q;
      2'd1:    w_digit = sh_sec_tens_q;
      2'd2:    w_digit = sh_min_ones_q;
      default: w_digit = sh_min_tens_q;
    endcase
  end

  always_comb begin
    case (w_digit)
      4'd0:    w_seg_dec = 7'b1000000;
      4'd1:    w_seg_dec = 7'b1111001;
      4'd2:    w_seg_dec = 7'b0100100;
      4'd3:    w_seg_dec = 7'b0110000;
      4'd4:    w_seg_dec = 7'b0011001;
      4'd5:    w_seg_dec = 7'b0010010;
      4'd6:    w_seg_dec = 7'b0000010;
      4'd7:    w_seg_dec = 7'b1111000;
      4'd8:    w_seg_dec = 7'b0000000;
      4'd9:    w_seg_dec = 7'b0010000;
      default: w_seg_dec = 7'b0111111;
    endcase
  end

  // idx_q[1] separates the minutes pair (2,3) from the seconds pair (0,1).
  assign w_blank = adj && blink_ph_q && (sel ? ~idx_q[1] : idx_q[1]);

  always_comb begin
    an_d  = c_AN_OFF;
    seg_d = c_SEG_OFF;
    dp_d  = 1'b1;
    if (!w_blank) begin
      an_d  = ~(4'b0001 << idx_q);
      seg_d = w_seg_dec;
      dp_d  = (idx_q != 2'd2);
    end
  end

  always_ff @(posedge master_clk or negedge rst) begin
    if (!rst) begin
      refresh_cnt_q <= '0;
      idx_q         <= '0;
      blink_cnt_q   <= '0;
      blink_ph_q    <= 1'b0;
      sh_min_tens_q <= '0;
      sh_min_ones_q <= '0;
      sh_sec_tens_q <= '0;
      sh_sec_ones_q <= '0;
      an_q          <= c_AN_OFF;
      seg_q         <= c_SEG_OFF;
      dp_q          <= 1'b1;
    end else begin
      refresh_cnt_q <= refresh_cnt_d;
      idx_q         <= idx_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_ph_q    <= blink_ph_d;
      sh_min_tens_q <= sh_min_tens_d;
      sh_min_ones_q <= sh_min_ones_d;
      sh_sec_tens_q <= sh_sec_tens_d;
      sh_sec_ones_q <= sh_sec_ones_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

`default_nettype wire

// File: tb/tb_stopwatch_display_scan.sv
// ============================================================================
// Module  : tb_stopwatch_display_scan
// Purpose : Directed self-checking bench for stopwatch_display_scan.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_stopwatch_display_scan;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic       adj, sel;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;

  int tests = 0;
  int fails = 0;

  stopwatch_display_scan #(
    .REFRESH_DIV(4),
    .BLINK_DIV  (16)
  ) dut (
    .master_clk(clk),
    .rst       (rst_n),
    .min_tens  (min_tens),
    .min_ones  (min_ones),
    .sec_tens  (sec_tens),
    .sec_ones  (sec_ones),
    .adj       (adj),
    .sel       (sel),
    .seg       (seg),
    .dp        (dp),
    .an        (an)
  );

  always #5 clk = ~clk;

  localparam logic [11:0] c_OFF = {4'b1111, 7'b1111111, 1'b1};

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  function automatic logic [11:0] expect_of(input int slot, input logic [3:0] d, input bit blank);
    logic [3:0] a;
    if (blank) return c_OFF;
    a = ~(4'b0001 << slot);
    return {a, seg_of(d), (slot != 2)};
  endfunction

  task automatic cmp(input string tag, input logic [11:0] exp);
    tests++;
    assert ({an, seg, dp} === exp) else begin
      fails++;
      $error("FAIL %s: an/seg/dp got %b/%b/%b expected %b/%b/%b",
             tag, an, seg, dp, exp[11:8], exp[7:1], exp[0]);
    end
  endtask

  task automatic check_cycle(input string tag, input int slot, input logic [3:0] d, input bit blank);
    @(posedge clk); #1;
    cmp($sformatf("%s slot%0d", tag, slot), expect_of(slot, d, blank));
  endtask

  task automatic check_slot(input string tag, input int slot, input logic [3:0] d, input bit blank);
    for (int c = 0; c < 4; c++) check_cycle(tag, slot, d, blank);
  endtask

  task automatic check_frame(input string tag, input logic [3:0] d0, input logic [3:0] d1,
                             input logic [3:0] d2, input logic [3:0] d3, input bit [3:0] blank);
    check_slot(tag, 0, d0, blank[0]);
    check_slot(tag, 1, d1, blank[1]);
    check_slot(tag, 2, d2, blank[2]);
    check_slot(tag, 3, d3, blank[3]);
  endtask

  initial begin
    rst_n = 1'b0;
    min_tens = 4'd1; min_ones = 4'd2; sec_tens = 4'd3; sec_ones = 4'd4;
    adj = 1'b0; sel = 1'b0;

    repeat (3) @(posedge clk);
    #1 cmp("reset hold", c_OFF);
    #2 rst_n = 1'b1;

    // Shadows start at zero, so the first frame shows 00:00.
    check_frame("frame0", 4'd0, 4'd0, 4'd0, 4'd0, 4'b0000);
    check_frame("frame1", 4'd4, 4'd3, 4'd2, 4'd1, 4'b0000);

    check_slot("tear", 0, 4'd4, 1'b0);
    sec_ones = 4'd9; min_ones = 4'd5;
    check_slot("tear", 1, 4'd3, 1'b0);
    check_slot("tear", 2, 4'd2, 1'b0);
    check_slot("tear", 3, 4'd1, 1'b0);
    check_frame("after tear", 4'd9, 4'd3, 4'd5, 4'd1, 4'b0000);

    min_tens = 4'hC;
    check_frame("pre dash", 4'd9, 4'd3, 4'd5, 4'd1, 4'b0000);
    check_frame("dash", 4'd9, 4'd3, 4'd5, 4'hC, 4'b0000);

    adj = 1'b1; sel = 1'b1;
    check_frame("blink sec ph0", 4'd9, 4'd3, 4'd5, 4'hC, 4'b0000);
    check_frame("blink sec ph1", 4'd9, 4'd3, 4'd5, 4'hC, 4'b0011);
    check_frame("blink sec ph0b", 4'd9, 4'd3, 4'd5, 4'hC, 4'b0000);

    sel = 1'b0;
    check_slot("blink min", 0, 4'd9, 1'b0);
    check_slot("blink min", 1, 4'd3, 1'b0);
    check_cycle("blink min", 2, 4'd5, 1'b1);
    check_cycle("blink min", 2, 4'd5, 1'b1);
    adj = 1'b0;
    @(posedge clk);
    check_cycle("adj exit", 2, 4'd5, 1'b0);
    tests++;
    assert (dut.blink_cnt_q === 4'd0 && dut.blink_ph_q === 1'b0) else begin
      fails++;
      $error("FAIL blink clear: cnt/ph got %0d/%0d expected 0/0", dut.blink_cnt_q, dut.blink_ph_q);
    end
    check_slot("adj exit", 3, 4'hC, 1'b0);

    check_slot("pre reset", 0, 4'd9, 1'b0);
    check_slot("pre reset", 1, 4'd3, 1'b0);
    check_cycle("pre reset", 2, 4'd5, 1'b0);
    #2 rst_n = 1'b0;
    #1 cmp("async reset", c_OFF);
    @(posedge clk); #1 cmp("reset held", c_OFF);
    #2 rst_n = 1'b1;
    check_slot("restart", 0, 4'd0, 1'b0);
    check_slot("restart", 1, 4'd0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/stopwatch_display_scan.md
Name: stopwatch_display_scan

Overview:
- Downstream consumer of the stopwatch core's BCD time digits (MM:SS).
- Time-multiplexes four digits onto the board's 4-digit active-low seven-segment display.
- When adjust mode is active, blinks the selected pair (minutes or seconds).
- Sits between the counter core and the display pins in the top-level; clocked by master_clk.

Parameters:
REFRESH_DIV, 100000, master_clk cycles each digit is shown; scan rate = f_clk/(4*REFRESH_DIV); must be >= 2
BLINK_DIV, 25000000, master_clk cycles per blink half-period; must be >= 2

Ports:
master_clk  input  1  system clock; all state on rising edge
rst  input  1  reset: asynchronous assert, active-low (0 = in reset)
min_tens  input  4  BCD minutes tens digit
min_ones  input  4  BCD minutes ones digit
sec_tens  input  4  BCD seconds tens digit
sec_ones  input  4  BCD seconds ones digit
adj  input  1  1 = adjust mode; enables blinking
sel  input  1  blink target in adjust mode: 1 = seconds pair, 0 = minutes pair
seg  output  7  cathodes {g,f,e,d,c,b,a}, active-low, registered
dp  output  1  decimal point, active-low, registered
an  output  4  anodes, active-low, registered; an[0] = rightmost digit

Behaviour:
- Reset (rst=0, asynchronous):
  - refresh_cnt=0, idx=0, blink_cnt=0, blink_ph=0.
  - Shadow digits all 0.
  - an=4'b1111, seg=7'b1111111, dp=1.
- Refresh counter:
  - refresh_cnt counts 0..REFRESH_DIV-1, then wraps to 0.
  - On wrap, idx increments mod 4 (0,1,2,3,0).
- Digit mapping:
  - idx0 = sec_ones on an[0].
  - idx1 = sec_tens on an[1].
  - idx2 = min_ones on an[2].
  - idx3 = min_tens on an[3].
- Shadow capture (anti-tearing):
  - All four inputs are latched into the shadow registers on the cycle where refresh_cnt wraps with idx==3 (frame boundary).
  - Displayed values come only from the shadows.
  - Input changes mid-frame are invisible until the next frame.
- Output registration:
  - Each cycle, an/seg/dp are registered from the current idx and shadow.
  - Outputs lag idx by exactly 1 cycle.
  - First edge after reset release: an=4'b1110, seg=7'b1000000 ("0").
- Decoder (active-low, gfedcba):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Values 10..15 show a dash: 0111111.
- Decimal point: dp=0 while idx==2 (colon substitute between MM and SS), else dp=1.
- Blink:
  - While adj=1: blink_cnt counts 0..BLINK_DIV-1; blink_ph toggles on each wrap.
  - While adj=0: blink_cnt and blink_ph held at 0 synchronously.
  - Blanking condition: adj=1 and blink_ph=1.
  - sel=1 blanks digits idx0/idx1; sel=0 blanks idx2/idx3.
  - A blanked digit drives an=4'b1111, seg=7'b1111111, dp=1.
  - Blank is evaluated from same-cycle adj/sel/blink_ph, with the same 1-cycle output lag.
- sel change mid-blink: takes effect on the next displayed digit; blink_ph not reset.
- adj deasserted while blink_ph=1: next cycle blink_ph=0 and no blanking (display visible within 2 cycles).
- Reset mid-scan: immediate return to reset values; scan restarts at idx0.
- Exactly one anode bit is low at any time, or none when blanked/in reset. Never two.

Test Plan:
1. Reset/first frame (REFRESH_DIV=4, BLINK_DIV=16, inputs 1,2,3,4 for MM:SS=12:34):
   - Hold rst=0 → an=1111, seg=1111111, dp=1.
   - Release rst → first frame shows shadow zeros (seg=1000000 on an 1110,1101,1011,0111, 4 cycles each).
   - From the second frame: an=1110 seg=0011001 (4), an=1101 seg=0110000 (3), an=1011 seg=0100100 dp=0 (2), an=0111 seg=1111001 (1).
2. Anti-tearing:
   - Change sec_ones 4→9 while idx=1.
   - Digit 0 shows 4 for the rest of the frame; shows 9 (0010000) only after the idx3→0 wrap.
3. Non-BCD: min_tens=4'hC → an=0111 with seg=0111111 on the following frame.
4. Blink seconds:
   - adj=1, sel=1.
   - For 16 cycles all digits are visible.
   - For the next 16 cycles an never equals 1110 or 1101 (outputs all-ones in those slots), while minutes stay visible.
   - Then visible again.
5. Blink minutes, then exit:
   - adj=1, sel=0 → digits idx2/idx3 blank in phase 1.
   - Drop adj mid-phase-1 → within 2 cycles an=1011/0111 reappear; blink_cnt reads 0.
6. Async reset mid-operation:
   - Assert rst=0 between clock edges at idx=2 → outputs go to 1111/1111111/1 without waiting for a clock.
   - After release, scan resumes at an=1110.
